dom_rand_gen_2ndorder: RTL and testbench

DOM_RAND_GEN_2NDORDER -- requirements
Module: dom_rand_gen_2ndorder

---
 rtl/dom_rand_gen_2ndorder_pkg.sv | 38 +++
 rtl/dom_rand_gen_2ndorder_lfsr32_adv8.sv | 19 +
 rtl/dom_rand_gen_2ndorder.sv | 86 ++++++++
 tb/tb_dom_rand_gen_2ndorder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom_rand_gen_2ndorder_pkg.sv
// Shared constants and types for the 2nd-order DOM mask generator:
// lane geometry, LFSR taps, lane-derivation masks and the seeds that would zero a lane.
package dom_rand_gen_2ndorder_pkg;

  localparam int LANE_W    = 32;
  localparam int SHARE_W   = 8;
  localparam int ADV_STEPS = 8;

  // x^32 + x^22 + x^2 + x + 1 expressed as state bit taps
  localparam int TAP_A = 31;
  localparam int TAP_B = 21;
  localparam int TAP_C = 1;
  localparam int TAP_D = 0;

  localparam logic [LANE_W-1:0] LANE1_MASK = 32'h5A5A5A5A;
  localparam logic [LANE_W-1:0] LANE2_MASK = 32'hA5A5A5A5;

  localparam int NUM_FORBIDDEN = 3;
  localparam logic [NUM_FORBIDDEN-1:0][LANE_W-1:0] FORBIDDEN_SEEDS =
    {32'h0000_0000, LANE1_MASK, LANE2_MASK};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_e;

  // A seed is forbidden when it would leave one of the three lanes all-zero
  function automatic logic is_forbidden(input logic [LANE_W-1:0] seed);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_FORBIDDEN; i++) begin
      if (seed == FORBIDDEN_SEEDS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/dom_rand_gen_2ndorder_lfsr32_adv8.sv
// Combinational 8-step advance of one 32-bit Fibonacci LFSR lane.
module lfsr32_adv8
  import dom_rand_gen_2ndorder_pkg::*;
(
  input  logic [LANE_W-1:0] lane_cur,
  output logic [LANE_W-1:0] lane_adv
);

  logic [LANE_W-1:0] work;

  always_comb begin
    work = lane_cur;
    for (int i = 0; i < ADV_STEPS; i++) begin
      work = {work[LANE_W-2:0], work[TAP_A] ^ work[TAP_B] ^ work[TAP_C] ^ work[TAP_D]};
    end
    lane_adv = work;
  end

endmodule

// File: rtl/dom_rand_gen_2ndorder.sv
// Fresh-mask generator for a 2nd-order DOM AND: three LFSR lanes seeded from one word,
// warmed up after each seed load, then advanced once per consumer handshake.
module dom_rand_gen_2ndorder
  import dom_rand_gen_2ndorder_pkg::*;
#(
  parameter int WARMUP_CYCLES = 4
)
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               seed_valid_i,
  input  logic [LANE_W-1:0]  seed_i,
  output logic               seed_ready_o,
  output logic               seed_err_o,
  output logic               rnd_valid_o,
  input  logic               rnd_ready_i,
  output logic [SHARE_W-1:0] Z0_o,
  output logic [SHARE_W-1:0] Z1_o,
  output logic [SHARE_W-1:0] Z2_o
);

  localparam logic [3:0] WARMUP_LAST = 4'(WARMUP_CYCLES - 1);

  state_e            state_q;
  logic [3:0]        warm_cnt_q;
  logic              seed_err_q;
  logic [LANE_W-1:0] lane_q   [3];
  logic [LANE_W-1:0] lane_adv [3];

  logic seed_offer;
  logic seed_accept;
  logic seed_reject;
  logic lane_advance;

  for (genvar g = 0; g < 3; g++) begin : g_lane
    lfsr32_adv8 u_adv (
      .lane_cur (lane_q[g]),
      .lane_adv (lane_adv[g])
    );
  end

  assign seed_ready_o = (state_q != WARMUP);
  assign rnd_valid_o  = (state_q == RUN);
  assign seed_err_o   = seed_err_q;

  assign Z0_o = lane_q[0][SHARE_W-1:0];
  assign Z1_o = lane_q[1][SHARE_W-1:0];
  assign Z2_o = lane_q[2][SHARE_W-1:0];

  assign seed_offer   = seed_valid_i & seed_ready_o;
  assign seed_accept  = seed_offer & ~is_forbidden(seed_i);
  assign seed_reject  = seed_offer &  is_forbidden(seed_i);
  assign lane_advance = (state_q == WARMUP) | ((state_q == RUN) & rnd_ready_i);

  // A seed load wins over a same-cycle handshake advance; the consumer still
  // takes the Z that was on the outputs during that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      warm_cnt_q <= '0;
      seed_err_q <= 1'b0;
      for (int i = 0; i < 3; i++) lane_q[i] <= '0;
    end else if (seed_accept) begin
      lane_q[0]  <= seed_i;
      lane_q[1]  <= seed_i ^ LANE1_MASK;
      lane_q[2]  <= seed_i ^ LANE2_MASK;
      seed_err_q <= 1'b0;
      state_q    <= WARMUP;
      warm_cnt_q <= '0;
    end else begin
      if (seed_reject) seed_err_q <= 1'b1;
      if (lane_advance) begin
        for (int i = 0; i < 3; i++) lane_q[i] <= lane_adv[i];
      end
      if (state_q == WARMUP) begin
        if (warm_cnt_q == WARMUP_LAST) begin
          state_q    <= RUN;
          warm_cnt_q <= '0;
        end else begin
          warm_cnt_q <= warm_cnt_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dom_rand_gen_2ndorder.sv
// Scoreboard bench for dom_rand_gen_2ndorder: lanes are modelled as bit-sequence
// recurrences in ring buffers, expected Z words queued at handshake time.
module tb_dom_rand_gen_2ndorder;

  localparam int WARMUP_CYCLES = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        seed_valid_i;
  logic [31:0] seed_i;
  logic        seed_ready_o;
  logic        seed_err_o;
  logic        rnd_valid_o;
  logic        rnd_ready_i;
  logic [7:0]  Z0_o;
  logic [7:0]  Z1_o;
  logic [7:0]  Z2_o;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          mon_hs       = 0;
  logic [23:0] sb_q [$];
  bit          exp_valid    = 1'b0;

  // Each lane is the sequence b(n+1) = b(n-31)^b(n-21)^b(n-1)^b(n); ptr marks the oldest bit
  bit          hist [3][32];
  int          ptr = 0;

  dom_rand_gen_2ndorder #(.WARMUP_CYCLES(WARMUP_CYCLES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .seed_valid_i (seed_valid_i),
    .seed_i       (seed_i),
    .seed_ready_o (seed_ready_o),
    .seed_err_o   (seed_err_o),
    .rnd_valid_o  (rnd_valid_o),
    .rnd_ready_i  (rnd_ready_i),
    .Z0_o         (Z0_o),
    .Z1_o         (Z1_o),
    .Z2_o         (Z2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_load(input logic [31:0] seed);
    logic [31:0] lane [3];
    lane[0] = seed;
    lane[1] = seed ^ 32'h5A5A5A5A;
    lane[2] = seed ^ 32'hA5A5A5A5;
    ptr = 0;
    for (int l = 0; l < 3; l++)
      for (int i = 0; i < 32; i++) hist[l][31-i] = lane[l][i];
  endtask

  task automatic model_advance();
    bit nb;
    for (int n = 0; n < 8; n++) begin
      for (int l = 0; l < 3; l++) begin
        nb = hist[l][ptr] ^ hist[l][(ptr+10)%32] ^ hist[l][(ptr+30)%32] ^ hist[l][(ptr+31)%32];
        hist[l][ptr] = nb;
      end
      ptr = (ptr + 1) % 32;
    end
  endtask

  function automatic logic [23:0] model_z();
    logic [23:0] z;
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < 8; j++) z[l*8+j] = hist[l][(ptr+31-j)%32];
    return z;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_output(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%06h expected 0x%06h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bit({tag, "_seed_ready"}, seed_ready_o, 1'b1);
    check_bit({tag, "_seed_err"}, seed_err_o, 1'b0);
    check_bit({tag, "_rnd_valid"}, rnd_valid_o, 1'b0);
    check_output({tag, "_z"}, {Z2_o, Z1_o, Z0_o}, 24'h0);
  endtask

  task automatic warmup_phase(input bit inject);
    for (int i = 0; i < WARMUP_CYCLES; i++) begin
      check_bit("warmup_seed_ready", seed_ready_o, 1'b0);
      if (inject && i == 1) begin
        seed_valid_i = 1'b1;
        seed_i       = 32'h0000_0000;
      end
      tick();
      seed_valid_i = 1'b0;
      model_advance();
    end
    exp_valid = 1'b1;
    check_bit("run_valid", rnd_valid_o, 1'b1);
    check_bit("run_seed_ready", seed_ready_o, 1'b1);
    check_output("run_first_z", {Z2_o, Z1_o, Z0_o}, model_z());
    if (inject) check_bit("warmup_offer_no_err", seed_err_o, 1'b0);
  endtask

  task automatic apply_stimulus(input logic [31:0] seed, input bit inject);
    seed_valid_i = 1'b1;
    seed_i       = seed;
    tick();
    seed_valid_i = 1'b0;
    model_load(seed);
    exp_valid = 1'b0;
    check_bit("seed_err_after_load", seed_err_o, 1'b0);
    warmup_phase(inject);
  endtask

  task automatic run_handshakes(input int n);
    int done;
    done = 0;
    while (done < n) begin
      rnd_ready_i = 1'($urandom_range(0, 1));
      if (rnd_ready_i) begin
        sb_q.push_back(model_z());
        model_advance();
        done++;
      end
      tick();
    end
    rnd_ready_i = 1'b0;
  endtask

  // Monitor: valid tracked every cycle, Z popped and compared on each handshake
  always @(negedge clk_i) begin
    if (!rst_i) begin
      check_bit("rnd_valid_track", rnd_valid_o, exp_valid);
      if (rnd_valid_o && rnd_ready_i) begin
        mon_hs++;
        if (sb_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL sb_unexpected_handshake: got z=0x%02h%02h%02h expected no handshake",
                   Z2_o, Z1_o, Z0_o);
        end else begin
          check_output("z_handshake", {Z2_o, Z1_o, Z0_o}, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    int hs_before;
    rst_i        = 1'b1;
    seed_valid_i = 1'b0;
    seed_i       = '0;
    rnd_ready_i  = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    rst_i = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      check_reset_outputs("idle_no_seed");
    end

    apply_stimulus(32'h0000_0001, 1'b0);
    run_handshakes(1000);

    rnd_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_output("hold_z", {Z2_o, Z1_o, Z0_o}, model_z());
      tick();
    end

    // Forbidden seed in RUN: flagged, but the handshake advance still happens
    seed_valid_i = 1'b1;
    seed_i       = 32'hA5A5A5A5;
    rnd_ready_i  = 1'b1;
    sb_q.push_back(model_z());
    model_advance();
    tick();
    seed_valid_i = 1'b0;
    rnd_ready_i  = 1'b0;
    check_bit("run_forbidden_err", seed_err_o, 1'b1);
    check_output("run_forbidden_z", {Z2_o, Z1_o, Z0_o}, model_z());
    run_handshakes(30);

    hs_before    = mon_hs;
    seed_valid_i = 1'b1;
    seed_i       = 32'hCAFEBABE;
    rnd_ready_i  = 1'b1;
    sb_q.push_back(model_z());
    tick();
    seed_valid_i = 1'b0;
    rnd_ready_i  = 1'b0;
    model_load(32'hCAFEBABE);
    exp_valid = 1'b0;
    check_output("reseed_handshakes", 24'(mon_hs - hs_before), 24'd1);
    check_bit("reseed_valid_drop", rnd_valid_o, 1'b0);
    check_bit("reseed_err_clear", seed_err_o, 1'b0);
    check_output("reseed_z", {Z2_o, Z1_o, Z0_o}, 24'h1BE4BE);
    warmup_phase(1'b0);
    run_handshakes(50);

    rst_i = 1'b1;
    exp_valid = 1'b0;
    tick();
    check_reset_outputs("sync_pulse_reset");
    rst_i = 1'b0;

    seed_valid_i = 1'b1;
    seed_i       = 32'h5A5A5A5A;
    tick();
    seed_valid_i = 1'b0;
    check_bit("idle_forbidden_err", seed_err_o, 1'b1);
    check_bit("idle_forbidden_ready", seed_ready_o, 1'b1);
    check_output("idle_forbidden_z", {Z2_o, Z1_o, Z0_o}, 24'h0);
    tick();
    check_bit("idle_err_sticky", seed_err_o, 1'b1);
    check_bit("idle_still_ready", seed_ready_o, 1'b1);

    apply_stimulus(32'h1234_5678, 1'b1);
    run_handshakes(50);

    // Async reset between edges in the middle of warm-up
    seed_valid_i = 1'b1;
    seed_i       = 32'h0BAD_F00D;
    tick();
    seed_valid_i = 1'b0;
    model_load(32'h0BAD_F00D);
    exp_valid = 1'b0;
    tick();
    check_bit("pre_async_in_warmup", seed_ready_o, 1'b0);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    #3;
    rst_i = 1'b0;
    tick();
    check_reset_outputs("after_async_edge");
    repeat (WARMUP_CYCLES + 2) tick();
    check_reset_outputs("needs_new_seed");

    check_output("sb_leftover", 24'(sb_q.size()), 24'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
